// File: rtl/crypto_in_arb_if.sv
// Bus bundle for crypto_in_arb: per-queue upstream word streams, the shared
// downstream port towards crypto, and the current grant index.
interface crypto_in_arb_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_QUEUES = 4
);
  localparam int unsigned QW = $clog2(NUM_QUEUES);

  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data_q;
  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl_q;
  logic [NUM_QUEUES-1:0]            in_wr_q;
  logic [NUM_QUEUES-1:0]            in_rdy_q;
  logic [DATA_WIDTH-1:0]            out_data;
  logic [CTRL_WIDTH-1:0]            out_ctrl;
  logic                             out_wr;
  logic                             out_rdy;
  logic [QW-1:0]                    cur_queue;

  modport master (
    output in_data_q, in_ctrl_q, in_wr_q, out_rdy,
    input  in_rdy_q, out_data, out_ctrl, out_wr, cur_queue
  );

  modport slave (
    input  in_data_q, in_ctrl_q, in_wr_q, out_rdy,
    output in_rdy_q, out_data, out_ctrl, out_wr, cur_queue
  );
endinterface

// File: rtl/crypto_in_arb.sv
// Packet-granular round-robin arbiter feeding the crypto datapath from several
// buffered queues. Optional per-queue EOP counters: CRYPTO_ARB_PKT_CNT_EN.
module crypto_in_arb #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_QUEUES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  crypto_in_arb_if.slave           bus
`ifdef CRYPTO_ARB_PKT_CNT_EN
  ,
  output logic [NUM_QUEUES*16-1:0] pkt_cnt
`endif
);

  localparam int unsigned QW    = $clog2(NUM_QUEUES);
  localparam int unsigned WW    = DATA_WIDTH + CTRL_WIDTH;
  localparam int unsigned DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    HDR     = 3'b010,
    PAYLOAD = 3'b100
  } state_t;

  state_t state, state_next;

  logic [NUM_QUEUES-1:0]         fifo_empty_c;
  logic [NUM_QUEUES-1:0][WW-1:0] fifo_head_c;
  logic [WW-1:0]                 head_c;
  logic [CTRL_WIDTH-1:0]         head_ctrl_c;
  logic [DATA_WIDTH-1:0]         head_data_c;
  logic                          rd_en_c;
  logic [QW-1:0]                 pick_c;
  logic                          pick_vld_c;
  logic [QW-1:0]                 cur_queue_next;
  logic                          out_wr_next;
  logic [DATA_WIDTH-1:0]         out_data_next;
  logic [CTRL_WIDTH-1:0]         out_ctrl_next;

  // Per-queue 4-entry fall-through FIFO; head word visible while non-empty.
  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_fifo
    logic [WW-1:0] mem [DEPTH];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic          wr_c;
    logic          rd_c;

    assign wr_c              = bus.in_wr_q[q] && (count != 3'(DEPTH));
    assign rd_c              = rd_en_c && (bus.cur_queue == QW'(q));
    assign fifo_empty_c[q]   = (count == 3'd0);
    assign fifo_head_c[q]    = mem[rd_ptr];
    assign bus.in_rdy_q[q]   = (count < 3'(DEPTH - 1));

    always_ff @(posedge clk) begin
      if (wr_c)
        mem[wr_ptr] <= {bus.in_ctrl_q[q*CTRL_WIDTH +: CTRL_WIDTH],
                        bus.in_data_q[q*DATA_WIDTH +: DATA_WIDTH]};
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        count  <= 3'd0;
      end else begin
        if (wr_c) wr_ptr <= wr_ptr + 2'd1;
        if (rd_c) rd_ptr <= rd_ptr + 2'd1;
        if (wr_c && !rd_c)      count <= count + 3'd1;
        else if (rd_c && !wr_c) count <= count - 3'd1;
      end
    end
  end

  assign head_c      = fifo_head_c[bus.cur_queue];
  assign head_ctrl_c = head_c[WW-1 -: CTRL_WIDTH];
  assign head_data_c = head_c[DATA_WIDTH-1:0];
  assign rd_en_c     = (state != IDLE) && !fifo_empty_c[bus.cur_queue] && bus.out_rdy;

  // Rotating priority: first non-empty queue after the last grant.
  always_comb begin
    logic [QW-1:0] idx;
    idx        = '0;
    pick_c     = bus.cur_queue;
    pick_vld_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_QUEUES; i++) begin
      idx = QW'(bus.cur_queue + QW'(i));
      if (!pick_vld_c && !fifo_empty_c[idx]) begin
        pick_c     = idx;
        pick_vld_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    cur_queue_next = bus.cur_queue;
    out_wr_next    = 1'b0;
    out_data_next  = bus.out_data;
    out_ctrl_next  = bus.out_ctrl;
    if (rd_en_c) begin
      out_wr_next   = 1'b1;
      out_data_next = head_data_c;
      out_ctrl_next = head_ctrl_c;
    end
    unique case (state)
      IDLE: begin
        if (pick_vld_c) begin
          cur_queue_next = pick_c;
          state_next     = HDR;
        end
      end
      HDR:     if (rd_en_c && head_ctrl_c == '0) state_next = PAYLOAD;
      PAYLOAD: if (rd_en_c && head_ctrl_c != '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.cur_queue <= QW'(NUM_QUEUES - 1);
      bus.out_wr    <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ctrl  <= '0;
    end else begin
      state         <= state_next;
      bus.cur_queue <= cur_queue_next;
      bus.out_wr    <= out_wr_next;
      bus.out_data  <= out_data_next;
      bus.out_ctrl  <= out_ctrl_next;
    end
  end

`ifdef CRYPTO_ARB_PKT_CNT_EN
  logic eop_c;
  assign eop_c = (state == PAYLOAD) && rd_en_c && (head_ctrl_c != '0);

  // Saturating count of packets completed per queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (eop_c && pkt_cnt[bus.cur_queue*16 +: 16] != 16'hFFFF) begin
      pkt_cnt[bus.cur_queue*16 +: 16] <= pkt_cnt[bus.cur_queue*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crypto_in_arb.sv
// Scoreboard bench for crypto_in_arb: directed packets per queue, expected
// words queued in output order and checked by an independent monitor.
module tb_crypto_in_arb;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned NQ = 4;
  localparam int unsigned QW = 2;

  typedef struct packed {
    logic [QW-1:0] q;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crypto_in_arb_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) bus ();
`ifdef CRYPTO_ARB_PKT_CNT_EN
  logic [NQ*16-1:0] pkt_cnt;
`endif

  crypto_in_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CRYPTO_ARB_PKT_CNT_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  word_t sb[$];
  word_t src [NQ][$];
  int    pkt_log[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    popped = 0;
  int    first_wr_cyc = -1;
  int    first_out_cyc = -1;
  bit    lat_arm = 1'b0;
  bit    check_gap = 1'b0;
  int    gap_from = 0;
  int    last_eop_cyc = 0;
  bit    in_pkt = 1'b0;
  bit    in_pay = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out_wr word must be the next scoreboard entry.
  always @(negedge clk) begin
    word_t e;
    if (reset) begin
      in_pkt = 1'b0;
      in_pay = 1'b0;
    end else if (bus.out_wr) begin
      popped++;
      if (lat_arm && first_out_cyc < 0) first_out_cyc = cyc;
      if (!in_pkt) begin
        check("pkt_starts_with_hdr", 64'(bus.out_ctrl != '0), 64'd1);
        pkt_log.push_back(int'(bus.cur_queue));
        if (check_gap && last_eop_cyc > gap_from)
          check("pkt_gap", 64'(cyc - last_eop_cyc), 64'd2);
        in_pkt = 1'b1;
        in_pay = 1'b0;
      end
      if (sb.size() == 0) begin
        check("unexpected_word_sb_size", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
        check("out_queue", 64'(bus.cur_queue), 64'(e.q));
      end
      if (bus.out_ctrl == '0) in_pay = 1'b1;
      else if (in_pay) begin
        in_pkt = 1'b0;
        last_eop_cyc = cyc;
      end
    end
  end

  // One clock of upstream driving: each queue writes its next word when ready.
  task automatic cycle();
    logic [NQ-1:0]    wr;
    logic [NQ*DW-1:0] d;
    logic [NQ*CW-1:0] c;
    word_t            w;
    @(posedge clk);
    #1;
    wr = '0;
    d  = bus.in_data_q;
    c  = bus.in_ctrl_q;
    for (int q = 0; q < int'(NQ); q++) begin
      if (src[q].size() > 0 && bus.in_rdy_q[q]) begin
        w = src[q].pop_front();
        wr[q] = 1'b1;
        d[q*DW +: DW] = w.data;
        c[q*CW +: CW] = w.ctrl;
        if (q == 2 && lat_arm && first_wr_cyc < 0) first_wr_cyc = cyc;
      end
    end
    bus.in_wr_q   = wr;
    bus.in_data_q = d;
    bus.in_ctrl_q = c;
  endtask

  task automatic send_pkt(input int q, input int nhdr, input int ndata, input int tag);
    word_t w;
    int    n;
    n = nhdr + ndata + 1;
    for (int k = 0; k < n; k++) begin
      w.q    = QW'(q);
      w.ctrl = (k < nhdr) ? 8'hFF : ((k == n - 1) ? 8'h04 : 8'h00);
      w.data = {8'(tag), 8'(q), 16'hC0DE, 32'(k)};
      src[q].push_back(w);
      sb.push_back(w);
    end
  endtask

  function automatic bit src_busy();
    bit b = 1'b0;
    for (int q = 0; q < int'(NQ); q++) if (src[q].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int max, input string name);
    int n = 0;
    while ((sb.size() > 0 || src_busy()) && n < max) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    check(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_popped(input int target, input int max, input string name);
    int n = 0;
    while (popped < target && n < max) begin
      cycle();
      n++;
    end
    check(name, 64'(popped >= target), 64'd1);
  endtask

  task automatic flush_tb();
    bus.in_wr_q = '0;
    sb.delete();
    for (int q = 0; q < int'(NQ); q++) src[q].delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_tb();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pkt_log.delete();
  endtask

  initial begin
    int p0;
    int inflight;
    int late;
    bus.in_wr_q   = '0;
    bus.in_data_q = '0;
    bus.in_ctrl_q = '0;
    bus.out_rdy   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_wr", 64'(bus.out_wr), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("rst_in_rdy", 64'(bus.in_rdy_q), 64'hF);
    check("rst_cur_queue", 64'(bus.cur_queue), 64'd3);
    reset = 1'b0;

    // Single packet on queue 2: latency and grant index.
    lat_arm = 1'b1;
    send_pkt(2, 2, 4, 8'h11);
    drain(200, "t1_drained");
    check("t1_latency", 64'(first_out_cyc - first_wr_cyc), 64'd3);
    check("t1_cur_queue", 64'(bus.cur_queue), 64'd2);
    lat_arm = 1'b0;

    // All four queues loaded together: rotation order and 1-cycle gaps.
    do_reset();
    for (int q = 0; q < int'(NQ); q++) send_pkt(q, 1, 3, 8'h20 + q);
    gap_from  = cyc;
    check_gap = 1'b1;
    drain(300, "t2_drained");
    check_gap = 1'b0;
    check("t2_pkt_count", 64'(pkt_log.size()), 64'd4);
    for (int i = 0; i < int'(NQ) && i < pkt_log.size(); i++)
      check("t2_order", 64'(pkt_log[i]), 64'(i));

    // Backpressure mid-payload on queue 1.
    do_reset();
    send_pkt(1, 2, 20, 8'h30);
    p0 = popped;
    wait_popped(p0 + 6, 100, "t3_reached_payload");
    bus.out_rdy = 1'b0;
    inflight = 0;
    late = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_wr) begin
        if (k == 0) inflight++;
        else late++;
      end
      cycle();
    end
    check("t3_inflight_le1", 64'(inflight <= 1), 64'd1);
    check("t3_late_wr", 64'(late), 64'd0);
    bus.out_rdy = 1'b1;
    drain(300, "t3_drained");

    // Queue 0 back-to-back while queue 3 waits: q3 must be served in between.
    do_reset();
    send_pkt(0, 1, 3, 8'h40);
    send_pkt(3, 1, 3, 8'h43);
    send_pkt(0, 1, 3, 8'h41);
    drain(300, "t4_drained");
    check("t4_pkt_count", 64'(pkt_log.size()), 64'd3);
    if (pkt_log.size() == 3) begin
      check("t4_first_q0", 64'(pkt_log[0]), 64'd0);
      check("t4_then_q3", 64'(pkt_log[1]), 64'd3);
      check("t4_then_q0", 64'(pkt_log[2]), 64'd0);
    end

    // Reset pulse in the payload of the third queue-1 packet.
    do_reset();
    for (int i = 0; i < 3; i++) send_pkt(1, 1, 6, 8'h50 + i);
    p0 = popped;
    wait_popped(p0 + 19, 300, "t5_reached_pkt3");
    reset = 1'b1;
    flush_tb();
    #1;
    check("t5_rst_out_wr", 64'(bus.out_wr), 64'd0);
    check("t5_rst_out_data", bus.out_data, 64'd0);
    check("t5_rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
    check("t5_rst_in_rdy", 64'(bus.in_rdy_q), 64'hF);
    check("t5_rst_cur_queue", 64'(bus.cur_queue), 64'd3);
`ifdef CRYPTO_ARB_PKT_CNT_EN
    check("t5_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    pkt_log.delete();
    send_pkt(2, 1, 2, 8'h60);
    drain(200, "t5_next_drained");
    check("t5_next_pkts", 64'(pkt_log.size()), 64'd1);
`ifdef CRYPTO_ARB_PKT_CNT_EN
    for (int i = 0; i < 3; i++) send_pkt(1, 1, 2, 8'h70 + i);
    drain(300, "t5_cnt_drained");
    check("t5_pkt_cnt_q1", 64'(pkt_cnt[31:16]), 64'd3);
    check("t5_pkt_cnt_q2", 64'(pkt_cnt[47:32]), 64'd1);
    check("t5_pkt_cnt_q0", 64'(pkt_cnt[15:0]), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
